// File: rtl/lif_pkg.sv
// Shared widths and types for the LIF synapse block.
// Optional macro SYN_INHIBIT_EN makes synapse INH_IDX inhibitory.
package lif_pkg;

  localparam int CURRENT_W = 8;
  localparam int N_SYN     = 4;
  localparam int SUM_W     = 11;
  // one extra bit keeps max current plus four full weights positive
  localparam int ACC_W     = SUM_W + 1;
  localparam int INH_IDX   = 3;

  typedef logic [CURRENT_W-1:0] weight_t;
  typedef weight_t [N_SYN-1:0]  weight_arr_t;

  function automatic weight_t sat_cur(
    input logic [ACC_W-1:0] v
  );
    if (v[ACC_W-1]) begin
      return '0;
    end else if (|v[ACC_W-2:CURRENT_W]) begin
      return '1;
    end else begin
      return v[CURRENT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_prescaler.sv
// Free-running leak prescaler; tick is high while the
// counter sits at all-ones, or every cycle with zero bits.
module lif_prescaler #(
  parameter int PRESCALE_BITS = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  generate
    if (PRESCALE_BITS == 0) begin : g_none
      assign o_tick = 1'b1;
    end else begin : g_cnt
      logic [PRESCALE_BITS-1:0] r_cnt;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + PRESCALE_BITS'(1);
        end
      end

      assign o_tick = &r_cnt;
    end
  endgenerate

endmodule

// File: rtl/lif_synapse.sv
// Four-input synapse integrating weighted spikes into a leaky current.
// Define SYN_INHIBIT_EN to make synapse 3 subtract its weight.
module lif_synapse
  import lif_pkg::*;
#(
  parameter int              DECAY_SHIFT   = 3,
  parameter int              PRESCALE_BITS = 2,
  parameter logic [7:0]      W_INIT        = 8'd32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SYN-1:0]   spike_in,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [7:0]         wr_data,
  output logic [7:0]         current,
  output logic               leak_tick
);

`ifdef SYN_INHIBIT_EN
  localparam logic [N_SYN-1:0] EXC_MASK = 4'b0111;
`else
  localparam logic [N_SYN-1:0] EXC_MASK = 4'b1111;
`endif

  weight_t          r_current;
  weight_arr_t      r_weights;

  logic             w_tick;
  weight_t          w_shift;
  weight_t          w_leak;
  logic [SUM_W-1:0] w_exc;
  logic [ACC_W-1:0] w_acc;
  logic [N_SYN-1:0] w_exc_spk;

  lif_prescaler #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_tick  (w_tick)
  );

  assign leak_tick = w_tick;
  assign current   = r_current;
  assign w_shift   = r_current >> DECAY_SHIFT;
  assign w_exc_spk = spike_in & EXC_MASK;

  // small nonzero currents still drain by one per tick
  always_comb begin
    w_leak = '0;
    if (w_tick) begin
      if (w_shift == '0 && r_current != '0) begin
        w_leak = 8'd1;
      end else begin
        w_leak = w_shift;
      end
    end
  end

  always_comb begin
    w_exc = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (w_exc_spk[i]) begin
        w_exc = w_exc + SUM_W'(r_weights[i]);
      end
    end
  end

`ifdef SYN_INHIBIT_EN
  weight_t w_inh;

  assign w_inh = spike_in[INH_IDX] ? r_weights[INH_IDX] : '0;
  assign w_acc = ACC_W'(r_current) - ACC_W'(w_leak)
               + ACC_W'(w_exc) - ACC_W'(w_inh);
`else
  assign w_acc = ACC_W'(r_current) - ACC_W'(w_leak)
               + ACC_W'(w_exc);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_current <= '0;
    end else begin
      r_current <= sat_cur(w_acc);
    end
  end

  // spikes read the old weight in the write cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SYN; i++) begin
        r_weights[i] <= W_INIT;
      end
    end else if (wr_en) begin
      r_weights[wr_addr] <= wr_data;
    end
  end

endmodule
